// File: rtl/ccu_r_burst_merge_if.sv
// R-channel bundle between NoInp read sources and the single merged master-side port.
// Fallback beat layout for when the instantiating block supplies no payload type.
typedef struct packed {
    logic [63:0] data;
    logic [1:0]  resp;
    logic        last;
} ccu_r_beat_t;

interface ccu_r_burst_merge_if #(
    parameter int unsigned NoInp    = 2,
    parameter type         r_chan_t = ccu_r_beat_t
);
    localparam int unsigned IdxW = (NoInp > 1) ? $clog2(NoInp) : 1;

    r_chan_t               inp_r_i [NoInp];
    logic    [NoInp-1:0]   inp_valid_i;
    logic    [NoInp-1:0]   inp_ready_o;
    r_chan_t               oup_r_o;
    logic                  oup_valid_o;
    logic                  oup_ready_i;
    logic    [IdxW-1:0]    oup_idx_o;
    logic                  locked_o;

    modport slave (
        input  inp_r_i, inp_valid_i, oup_ready_i,
        output inp_ready_o, oup_r_o, oup_valid_o, oup_idx_o, locked_o
    );

    modport master (
        output inp_r_i, inp_valid_i, oup_ready_i,
        input  inp_ready_o, oup_r_o, oup_valid_o, oup_idx_o, locked_o
    );
endinterface

// File: rtl/ccu_r_burst_merge.sv
// N-input R-channel merger: round-robin or fixed-priority grant, burst locking until last,
// and an optional 2-entry spill stage that cuts the ready path back to the sources.
module ccu_r_burst_merge #(
    parameter int unsigned NoInp      = 2,
    parameter type         r_chan_t   = ccu_r_beat_t,
    parameter bit          RoundRobin = 1'b1,
    parameter bit          LockBursts = 1'b1,
    parameter bit          SpillReg   = 1'b0
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    ccu_r_burst_merge_if.slave bus
);
    localparam int unsigned IdxW = (NoInp > 1) ? $clog2(NoInp) : 1;
    localparam int          NInp = int'(NoInp);

    typedef logic [IdxW-1:0] idx_t;
    typedef enum logic {IDLE, BURST} lock_state_e;

    lock_state_e state_reg, state_next;
    idx_t        lock_idx_reg, lock_idx_next;
    idx_t        rr_ptr_reg, rr_ptr_next;
    logic        pend_reg, pend_next;
    idx_t        pend_idx_reg, pend_idx_next;

    idx_t    arb_idx;
    logic    arb_found;
    int      cand;
    idx_t    sel;
    logic    stage_valid;
    logic    stage_ready;
    logic    stage_hs;
    logic    stage_last;
    r_chan_t stage_r;

    always_comb begin
        arb_idx   = '0;
        arb_found = 1'b0;
        cand      = 0;
        for (int k = 0; k < NInp; k++) begin
            cand = RoundRobin ? (int'(rr_ptr_reg) + k) % NInp : k;
            if (!arb_found && bus.inp_valid_i[cand]) begin
                arb_found = 1'b1;
                arb_idx   = idx_t'(cand);
            end
        end
    end

    // A burst owner or an offered-but-unaccepted winner keeps the grant against newcomers.
    always_comb begin
        if (state_reg == BURST) begin
            sel = lock_idx_reg;
        end else if (pend_reg) begin
            sel = pend_idx_reg;
        end else begin
            sel = arb_idx;
        end
    end

    assign stage_r     = bus.inp_r_i[sel];
    assign stage_last  = stage_r.last;
    assign stage_valid = rst_ni && bus.inp_valid_i[sel];
    assign stage_hs    = stage_valid && stage_ready;
    assign bus.locked_o = (state_reg == BURST);

    always_comb begin
        bus.inp_ready_o      = '0;
        bus.inp_ready_o[sel] = stage_ready;
    end

    always_comb begin
        state_next    = state_reg;
        lock_idx_next = lock_idx_reg;
        rr_ptr_next   = rr_ptr_reg;
        pend_next     = pend_reg;
        pend_idx_next = pend_idx_reg;

        if (stage_hs) begin
            pend_next = 1'b0;
        end else if (stage_valid && state_reg == IDLE) begin
            pend_next     = 1'b1;
            pend_idx_next = sel;
        end

        case (state_reg)
            IDLE: begin
                if (stage_hs && !stage_last && LockBursts) begin
                    state_next    = BURST;
                    lock_idx_next = sel;
                end
            end
            BURST: begin
                if (stage_hs && stage_last) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase

        if (RoundRobin && stage_hs && (stage_last || !LockBursts)) begin
            rr_ptr_next = idx_t'((int'(sel) + 1) % NInp);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg    <= IDLE;
            lock_idx_reg <= '0;
            rr_ptr_reg   <= '0;
            pend_reg     <= 1'b0;
            pend_idx_reg <= '0;
        end else begin
            state_reg    <= state_next;
            lock_idx_reg <= lock_idx_next;
            rr_ptr_reg   <= rr_ptr_next;
            pend_reg     <= pend_next;
            pend_idx_reg <= pend_idx_next;
        end
    end

    generate
        if (SpillReg) begin : g_spill
            r_chan_t    r_mem   [2];
            idx_t       idx_mem [2];
            logic       wr_ptr_reg;
            logic       rd_ptr_reg;
            logic [1:0] cnt_reg;
            logic       out_valid;
            logic       pop;

            // Ready depends only on occupancy, so the master's ready never reaches the sources.
            assign stage_ready     = rst_ni && (cnt_reg != 2'd2);
            assign out_valid       = (cnt_reg != 2'd0);
            assign pop             = out_valid && bus.oup_ready_i;
            assign bus.oup_valid_o = out_valid;
            assign bus.oup_r_o     = r_mem[rd_ptr_reg];
            assign bus.oup_idx_o   = out_valid ? idx_mem[rd_ptr_reg] : '0;

            always_ff @(posedge clk_i) begin
                if (stage_hs) begin
                    r_mem[wr_ptr_reg]   <= stage_r;
                    idx_mem[wr_ptr_reg] <= sel;
                end
            end

            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    wr_ptr_reg <= 1'b0;
                    rd_ptr_reg <= 1'b0;
                    cnt_reg    <= 2'd0;
                end else begin
                    if (stage_hs) wr_ptr_reg <= ~wr_ptr_reg;
                    if (pop)      rd_ptr_reg <= ~rd_ptr_reg;
                    cnt_reg <= cnt_reg + 2'(stage_hs) - 2'(pop);
                end
            end
        end else begin : g_comb
            assign stage_ready     = rst_ni && bus.oup_ready_i;
            assign bus.oup_valid_o = stage_valid;
            assign bus.oup_r_o     = stage_r;
            assign bus.oup_idx_o   = stage_valid ? sel : '0;
        end
    endgenerate

    for (genvar gi = 0; gi < NInp; gi++) begin : g_chk
        a_inp_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
            bus.inp_valid_i[gi] && !bus.inp_ready_o[gi] |=> $stable(bus.inp_r_i[gi]));
    end

    a_oup_hold: assert property (@(posedge clk_i) disable iff (!rst_ni)
        bus.oup_valid_o && !bus.oup_ready_i |=> bus.oup_valid_o);

    a_ready_onehot: assert property (@(posedge clk_i) disable iff (!rst_ni)
        $onehot0(bus.inp_ready_o));
endmodule

// File: tb/tb_ccu_r_burst_merge.sv
// Randomised scoreboard bench for ccu_r_burst_merge over several parameter sets running side by side.
module tb_ccu_r_burst_merge;
    typedef struct packed {
        logic [15:0] data;
        logic        last;
    } beat_t;

    localparam int NCFG = 6;

    function automatic int cfg_n(input int g);
        case (g)
            0: return 2;
            1: return 3;
            2: return 2;
            3: return 3;
            4: return 1;
            default: return 3;
        endcase
    endfunction

    function automatic bit cfg_rr(input int g);
        return (g != 1);
    endfunction

    function automatic bit cfg_lock(input int g);
        return (g != 3);
    endfunction

    function automatic bit cfg_spill(input int g);
        return (g == 2 || g == 4 || g == 5);
    endfunction

    logic clk;
    int   tests;
    int   fails;
    bit   done [NCFG];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input int cfg, input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL cfg%0d %s: got %0h expected %0h", cfg, name, act, exp);
        end
    endtask

    for (genvar gi = 0; gi < NCFG; gi++) begin : g_cfg
        localparam int N  = cfg_n(gi);
        localparam bit RR = cfg_rr(gi);
        localparam bit LK = cfg_lock(gi);
        localparam bit SP = cfg_spill(gi);
        localparam int IW = (N > 1) ? $clog2(N) : 1;
        localparam int RS = N - 1;

        typedef struct packed {
            beat_t         r;
            logic [IW-1:0] idx;
        } exp_t;

        logic         rst_n;
        beat_t        rin [N];
        logic [N-1:0] valid;
        logic         oready;

        ccu_r_burst_merge_if #(.NoInp(N), .r_chan_t(beat_t)) bus ();

        assign bus.inp_r_i     = rin;
        assign bus.inp_valid_i = valid;
        assign bus.oup_ready_i = oready;

        ccu_r_burst_merge #(
            .NoInp(N), .r_chan_t(beat_t), .RoundRobin(RR), .LockBursts(LK), .SpillReg(SP)
        ) dut (
            .clk_i (clk),
            .rst_ni(rst_n),
            .bus   (bus)
        );

        // Source side state (driver) and reference model state.
        beat_t        srcq [N][$];
        logic [N-1:0] pres;
        int           seen   [N];
        int           hs_cnt [N];
        int           n_acc_rs;
        exp_t         expq [$];
        int           m_ptr;
        int           m_w;
        int           m_cnt;
        bit           m_locked;
        bit           m_have;

        // Model: decides the winner from the spec rules and scores every handshake.
        always @(negedge clk) begin
            if (!rst_n) begin
                expq.delete();
                m_ptr    = 0;
                m_w      = 0;
                m_cnt    = 0;
                m_locked = 1'b0;
                m_have   = 1'b0;
            end else begin
                logic         sr;
                logic         ihs;
                logic         ohs;
                logic [N-1:0] exp_rdy;
                exp_t         e;
                if (!m_locked && !m_have) begin
                    for (int k = 0; k < N; k++) begin
                        int c;
                        c = RR ? (m_ptr + k) % N : k;
                        if (!m_have && valid[c]) begin
                            m_have = 1'b1;
                            m_w    = c;
                        end
                    end
                end
                sr = SP ? (m_cnt < 2) : oready;
                if (m_locked || m_have) begin
                    exp_rdy       = '0;
                    exp_rdy[m_w]  = sr;
                    check(gi, "inp_ready", 64'(bus.inp_ready_o), 64'(exp_rdy));
                end
                ihs = (m_locked || m_have) && valid[m_w] && sr;
                if (SP) check(gi, "oup_valid", 64'(bus.oup_valid_o), 64'(m_cnt > 0));
                else    check(gi, "oup_valid", 64'(bus.oup_valid_o), 64'((m_locked || m_have) && valid[m_w]));
                check(gi, "locked", 64'(bus.locked_o), 64'(m_locked));
                if (ihs) begin
                    e.r   = rin[m_w];
                    e.idx = IW'(m_w);
                    expq.push_back(e);
                    hs_cnt[m_w]++;
                end
                ohs = bus.oup_valid_o && oready;
                if (ohs) begin
                    check(gi, "beat_expected", 64'(expq.size() != 0), 64'(1));
                    if (expq.size() != 0) begin
                        e = expq.pop_front();
                        $display("[cfg%0d] beat src=%0d data=%04h last=%0b", gi, bus.oup_idx_o,
                                 bus.oup_r_o.data, bus.oup_r_o.last);
                        check(gi, "oup_r", 64'(bus.oup_r_o), 64'(e.r));
                        check(gi, "oup_idx", 64'(bus.oup_idx_o), 64'(e.idx));
                    end
                end
                if (ihs) begin
                    if (rin[m_w].last || !LK) begin
                        m_locked = 1'b0;
                        if (RR) m_ptr = (m_w + 1) % N;
                    end else begin
                        m_locked = 1'b1;
                    end
                    m_have = 1'b0;
                end
                m_cnt = m_cnt + int'(ihs) - int'(ohs);
            end
        end

        task automatic drive();
            for (int s = 0; s < N; s++) begin
                valid[s] = pres[s];
                rin[s]   = pres[s] ? srcq[s][0] : beat_t'(17'($urandom));
            end
        endtask

        task automatic step();
            for (int s = 0; s < N; s++) begin
                if (hs_cnt[s] != seen[s]) begin
                    seen[s] = hs_cnt[s];
                    void'(srcq[s].pop_front());
                    pres[s] = 1'b0;
                    if (s == RS) n_acc_rs++;
                end
                if (!pres[s] && srcq[s].size() > 0 && $urandom_range(9, 0) < 7) pres[s] = 1'b1;
            end
            oready = ($urandom_range(3, 0) != 0);
            drive();
        endtask

        task automatic load_burst(input int s, input int len);
            beat_t b;
            for (int i = 0; i < len; i++) begin
                b.data = 16'($urandom);
                b.last = (i == len - 1);
                srcq[s].push_back(b);
            end
        endtask

        task automatic load(input int nb);
            for (int s = 0; s < N; s++)
                for (int b = 0; b < nb; b++)
                    load_burst(s, int'($urandom_range(4, 1)));
        endtask

        task automatic drain(input int bound);
            int cyc;
            bit busy;
            cyc  = 0;
            busy = 1'b1;
            while (busy && cyc < bound) begin
                @(posedge clk);
                #1;
                step();
                cyc++;
                busy = (pres != '0) || (expq.size() != 0);
                for (int s = 0; s < N; s++) if (srcq[s].size() != 0) busy = 1'b1;
            end
            check(gi, "drain", 64'(busy), 64'(0));
        endtask

        initial begin
            int cyc;
            done[gi] = 1'b0;
            rst_n    = 1'b0;
            oready   = 1'b0;
            pres     = '0;
            n_acc_rs = 0;
            drive();
            repeat (3) @(posedge clk);
            #1;
            check(gi, "rst_oup_valid", 64'(bus.oup_valid_o), 64'(0));
            check(gi, "rst_locked", 64'(bus.locked_o), 64'(0));
            check(gi, "rst_oup_idx", 64'(bus.oup_idx_o), 64'(0));
            rst_n = 1'b1;
            load(30);
            drain(5000);

            // Asynchronous reset in the middle of a 4-beat burst.
            n_acc_rs = 0;
            load_burst(RS, 4);
            cyc = 0;
            while (n_acc_rs < 2 && cyc < 500) begin
                @(posedge clk);
                #1;
                step();
                cyc++;
            end
            check(gi, "burst_progress", 64'(n_acc_rs), 64'(2));
            #2 rst_n = 1'b0;
            #1;
            check(gi, "midrst_oup_valid", 64'(bus.oup_valid_o), 64'(0));
            check(gi, "midrst_locked", 64'(bus.locked_o), 64'(0));
            check(gi, "midrst_inp_ready", 64'(bus.inp_ready_o), 64'(0));
            for (int s = 0; s < N; s++) srcq[s].delete();
            pres = '0;
            drive();
            repeat (2) @(posedge clk);
            #1 rst_n = 1'b1;
            for (int s = 0; s < N; s++) load_burst(s, 1);
            pres   = '1;
            oready = 1'b1;
            drive();
            load(10);
            drain(3000);
            done[gi] = 1'b1;
        end
    end

    initial begin
        bit all;
        all = 1'b0;
        for (int c = 0; c < 80000 && !all; c++) begin
            @(posedge clk);
            all = 1'b1;
            for (int g = 0; g < NCFG; g++) if (!done[g]) all = 1'b0;
        end
        check(-1, "all_configs_done", 64'(all), 64'(1));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
